// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: load, shift, rotate and count,
// with a registered shift-out / carry / borrow flag.
module univ_reg #(
  parameter int WIDTH     = 8,
  parameter     RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             flag
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROTL = 3'b100,
    M_ROTR = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             flag_q, flag_d;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  always_comb begin
    q_d    = q_q;
    flag_d = flag_q;
    if (clr) begin
      q_d    = RST_V;
      flag_d = 1'b0;
    end else if (en) begin
      unique case (mode_s)
        M_HOLD: ;
        M_LOAD: begin
          q_d    = D;
          flag_d = 1'b0;
        end
        M_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          flag_d = q_q[WIDTH-1];
        end
        M_SHR: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          flag_d = q_q[0];
        end
        M_ROTL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          flag_d = q_q[WIDTH-1];
        end
        M_ROTR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          flag_d = q_q[0];
        end
        // Carry / borrow come out of the widened add / subtract
        M_INC: {flag_d, q_d} = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
        M_DEC: {flag_d, q_d} = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_V;
      flag_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      flag_q <= flag_d;
    end
  end

  assign Q    = q_q;
  assign flag = flag_q;

endmodule

// File: doc/univ_reg.md
# univ_reg

Parametrised universal register: a WIDTH-bit edge-triggered register with synchronous enable, synchronous clear, and eight operating modes (hold, parallel load, logical shift left/right, rotate left/right, increment, decrement). It replaces single-bit flip-flop instances wherever a datapath needs a multi-bit shift, rotate or count register with a registered carry/shift-out flag. It sits in the register library next to the latch and flip-flop primitives.

## Interface
Parameters:
- WIDTH, default 8: register width in bits; legal range ≥ 2.
- RESET_VAL, default 0: value loaded into Q on reset and on clr; WIDTH bits, truncated if wider.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  operation enable; 0 = hold regardless of mode.
- clr  input  1  synchronous clear.
- mode  input  3  operation select; encoding under Operation.
- D  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for shift modes.
- Q  output  WIDTH  register contents.
- flag  output  1  registered shift-out / carry / borrow bit.

## Operation
- Priority, highest first: rst_n low > clr > en low > mode.
- rst_n low:
  - Q = RESET_VAL and flag = 0 immediately.
  - Both held while rst_n stays low.
- clr = 1 at posedge: Q = RESET_VAL, flag = 0; en and mode ignored.
- en = 0 at posedge (clr = 0): Q and flag hold.
- en = 1, clr = 0, by mode:
  - 000 hold: Q and flag unchanged.
  - 001 load: Q = D; flag = 0.
  - 010 shl: Q = {Q[WIDTH-2:0], sin}; flag = old Q[WIDTH-1].
  - 011 shr: Q = {sin, Q[WIDTH-1:1]}; flag = old Q[0].
  - 100 rotl: Q = {Q[WIDTH-2:0], Q[WIDTH-1]}; flag = old Q[WIDTH-1]; sin ignored.
  - 101 rotr: Q = {Q[0], Q[WIDTH-1:1]}; flag = old Q[0]; sin ignored.
  - 110 inc: Q = Q + 1 mod 2^WIDTH; flag = 1 iff old Q was all-ones (wrap to 0), else 0.
  - 111 dec: Q = Q − 1 mod 2^WIDTH; flag = 1 iff old Q was 0 (wrap to all-ones), else 0.
- Arithmetic is unsigned WIDTH-bit with wrap-around; no saturation.
- flag is overwritten by every enabled non-hold operation. It is never sticky.
- D and sin are sampled only in modes that use them. Their values in other modes have no effect.

## Timing
- Latency: one clock. Q and flag reflect the operation selected at posedge N immediately after posedge N.
- Q and flag are pure register outputs with no combinational path from any input.
- Inputs must be stable for setup/hold around posedge clk.
- Reset:
  - Assertion is asynchronous: outputs change without a clock edge.
  - Deassertion is synchronised by the integrator. The first operation takes effect at the first posedge with rst_n high.
- Reset mid-operation (e.g. during an inc sequence): Q = RESET_VAL and flag = 0 at once. No partial update is retained.
- Simultaneous events:
  - clr with any en/mode gives the clear result.
  - rst_n low with clr gives the reset result.
- Mode changes take effect at the next posedge. There is no pipeline, so back-to-back different modes each act on the previous cycle's Q.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with Q = 8'h5A (WIDTH = 8, RESET_VAL = 8'h3C) -> Q = 8'h3C and flag = 0 before the next posedge; both hold while rst_n = 0.
- Load/hold/enable:
  - Load D = 8'hA5 -> Q = 8'hA5, flag = 0.
  - Then en = 0 with mode = inc for 3 cycles -> Q stays 8'hA5.
  - Then mode = 000, en = 1 -> Q still 8'hA5.
- Shift:
  - From Q = 8'b1000_0001, shl with sin = 0 -> Q = 8'b0000_0010, flag = 1.
  - Then shr with sin = 1 -> Q = 8'b1000_0001, flag = 0.
- Rotate:
  - From Q = 8'h81, rotl -> Q = 8'h03, flag = 1.
  - rotr ×2 -> Q = 8'hC0 then 8'h60, flags 1 then 0.
- Counter wrap:
  - Load 8'hFE; inc ×2 -> Q = 8'hFF with flag = 0, then Q = 8'h00 with flag = 1.
  - dec -> Q = 8'hFF, flag = 1.
- Priority: assert clr with en = 1, mode = load, D = 8'h77 -> Q = RESET_VAL, flag = 0. Repeat with WIDTH = 16 and RESET_VAL = 16'hFFFF; inc from RESET_VAL -> Q = 16'h0000, flag = 1.
